// File: rtl/fetch_controller.sv
// fetch_controller: owns the program counter, issues reads to the synchronous
// instruction ROM, buffers returned words in a small FIFO and presents them to
// decode over a valid/ready handshake. Branch redirects flush wrong-path words;
// a HALT opcode stops fetching once the HALT word itself has been delivered.
module fetch_controller #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [3:0]        HALT_OP   = 4'hF,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              rom_read,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
    output logic              halted
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic              inflight;        // a ROM word returns this cycle
    logic [ADDR_W-1:0] inflight_pc;     // address that word was read from

    logic [DATA_W-1:0] buf_data [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;

    logic accept;
    logic buf_write;
    logic halt_arriving;
    logic head_is_halt;
    logic room;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign instr_valid   = (count != '0);
    assign instr         = buf_data[rd_ptr];
    assign instr_pc      = buf_pc[rd_ptr];
    assign accept        = instr_valid && instr_ready;
    assign head_is_halt  = instr_valid && (instr[DATA_W-1 -: 4] == HALT_OP);
    assign halt_arriving = inflight && (rom_data[DATA_W-1 -: 4] == HALT_OP);

    // A returning word is kept only while still fetching on the same path;
    // in DRAIN it was issued behind a HALT word and is dropped.
    assign buf_write = inflight && (state == FETCH) && !redirect;

    // The head leaving this cycle frees its slot, which keeps one word per
    // cycle flowing with only two entries; the returning word already owns one.
    assign room = (int'(count) + int'(inflight) - int'(accept)) < BUF_DEPTH;

    // Never issue past a HALT word that is arriving right now.
    assign rom_read = (state == FETCH) && !redirect && !halt_arriving && room;
    assign rom_addr = pc;

    assign busy   = (state == FETCH) || (state == DRAIN);
    assign halted = (state == HALTED);

    // Next state and next PC; redirect wins over issue and over start.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next = state;
        pc_next    = pc;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                if (buf_write && halt_arriving) state_next = DRAIN;
            end
            DRAIN: begin
                if (redirect)                    state_next = FETCH;
                else if (accept && head_is_halt) state_next = HALTED;
            end
            HALTED: begin
                if (start) begin
                    state_next = FETCH;
                    pc_next    = RESET_PC;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect)      pc_next = redirect_pc;
        else if (rom_read) pc_next = pc + ADDR_W'(1);
    end

    // State, PC and in-flight read tracking.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            inflight <= rom_read;
            if (rom_read) inflight_pc <= pc;
        end
    end

    // Output FIFO: write returning words, pop on accept, empty on redirect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: the storage is reset as well because the head entry drives
            // instr/instr_pc, which must read zero out of reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (buf_write) begin
                buf_data[wr_ptr] <= rom_data;
                buf_pc[wr_ptr]   <= inflight_pc;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (accept) rd_ptr <= ptr_inc(rd_ptr);
            if (buf_write && !accept)      count <= count + CNT_W'(1);
            else if (!buf_write && accept) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a ROM model, directed scenarios, then random
// start/ready/redirect traffic scored against a program-order reference.
module tb_fetch_controller;

    localparam int         BUF_DEPTH = 2;
    localparam logic [7:0] RESET_PC  = 8'h00;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rom_read;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        busy;
    logic        halted;

    fetch_controller dut (
        .clock(clock), .reset(reset), .start(start),
        .rom_read(rom_read), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .busy(busy), .halted(halted)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: word valid one cycle after the read; junk otherwise.
    logic [15:0] rom [256];
    always @(posedge clock) rom_data <= rom_read ? rom[rom_addr] : 16'($urandom);

    int checks = 0;
    int errors = 0;

    // Reference: the delivered stream is program order from exp_pc, restarted
    // by redirects; running/halted follow start, HALT delivery and redirect.
    logic [7:0] exp_pc = RESET_PC;
    bit         m_run = 0;
    bit         m_halted = 0;
    logic [7:0] acc_pcs[$];
    int         outstanding = 0;
    int         stall = 0;
    logic       last_valid;
    logic       last_rom_read;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; score at negedge, update the
    // model at posedge, compare status just after the edge.
    task automatic step();
        logic acc;
        logic acc_halt;
        @(negedge clock);
        last_valid    = instr_valid;
        last_rom_read = rom_read;
        acc      = instr_valid && instr_ready;
        acc_halt = 1'b0;
        if (!m_run) check("valid_when_stopped", instr_valid, 1'b0);
        if (acc) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, rom[exp_pc]);
            acc_pcs.push_back(instr_pc);
            acc_halt = (rom[exp_pc][15:12] == 4'hF);
            exp_pc = exp_pc + 8'd1;
        end
        if (redirect) outstanding = 0;
        else outstanding += int'(rom_read) - int'(acc);
        if (m_run && !acc && !redirect) stall++;
        else stall = 0;
        if (stall > 60) begin
            check("progress", 32'(stall), 32'd60);
            stall = 0;
        end
        @(posedge clock);
        if (redirect) begin
            exp_pc = redirect_pc;
            if (m_run || start) begin
                m_run    = 1;
                m_halted = 0;
            end
        end else if (acc_halt) begin
            m_run    = 0;
            m_halted = 1;
        end else if (start && !m_run) begin
            if (m_halted) exp_pc = RESET_PC;
            m_run    = 1;
            m_halted = 0;
        end
        #1;
        check("busy", busy, m_run);
        check("halted", halted, m_halted);
    endtask

    task automatic run_until_halted(input int budget);
        int n;
        n = 0;
        instr_ready = 1'b1;
        while (!m_halted && n < budget) begin
            step();
            n++;
        end
        if (!m_halted) check("halt_timeout", 32'(n), 32'(budget + 1));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        rom[0]    = 16'h1111;
        rom[1]    = 16'h2222;
        rom[2]    = 16'h3333;
        rom[3]    = 16'hF000;
        rom[8'h48] = 16'hF123;
        rom[8'h81] = 16'hF000;
        rom[8'h98] = 16'hF0AA;

        // Reset state.
        #12;
        check("rst_rom_read", rom_read, 1'b0);
        check("rst_rom_addr", rom_addr, RESET_PC);
        check("rst_instr", instr, 16'h0);
        check("rst_instr_pc", instr_pc, 8'h0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Full throughput to HALT: start is sampled at edge 0, the first read
        // issues in the next cycle and its word is at the head two edges later.
        start = 1'b1;
        instr_ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("thru_valid", last_valid, (k >= 3 && k <= 6));
        end
        check("halt_rom_read", last_rom_read, 1'b0);
        check("halt_state", halted, 1'b1);

        // Stall mid-stream, then refill and redirect while full.
        start = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'h10;
        step();
        start = 1'b0;
        redirect = 1'b0;
        for (int k = 0; k < 4; k++) step();
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("stall_held", 32'(outstanding), 32'(BUF_DEPTH));
        check("stall_no_read", last_rom_read, 1'b0);
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("full_before_redirect", 32'(outstanding), 32'(BUF_DEPTH));
        redirect = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        step();
        check("flush_valid", last_valid, 1'b0);
        acc_pcs.delete();
        run_until_halted(50);
        check("redirect_first_pc", acc_pcs.size() > 0 ? acc_pcs[0] : 8'hXX, 8'h40);

        // PC wrap: restart at FE via start+redirect from HALTED.
        acc_pcs.delete();
        start = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        step();
        start = 1'b0;
        redirect = 1'b0;
        run_until_halted(50);
        check("wrap_count", 32'(acc_pcs.size()), 32'd6);
        if (acc_pcs.size() >= 4) begin
            check("wrap_pc0", acc_pcs[0], 8'hFE);
            check("wrap_pc1", acc_pcs[1], 8'hFF);
            check("wrap_pc2", acc_pcs[2], 8'h00);
            check("wrap_pc3", acc_pcs[3], 8'h01);
        end

        // Plain start from HALTED resumes at RESET_PC.
        acc_pcs.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_halted(50);
        check("restart_count", 32'(acc_pcs.size()), 32'd4);
        check("restart_pc", acc_pcs.size() > 0 ? acc_pcs[0] : 8'hXX, RESET_PC);

        // Redirect while draining a captured HALT.
        start = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'h80;
        instr_ready = 1'b0;
        step();
        start = 1'b0;
        redirect = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("drain_no_read", last_rom_read, 1'b0);
        check("drain_valid", last_valid, 1'b1);
        redirect = 1'b1;
        redirect_pc = 8'h90;
        step();
        redirect = 1'b0;
        acc_pcs.delete();
        run_until_halted(50);
        check("drain_redirect_pc", acc_pcs.size() > 0 ? acc_pcs[0] : 8'hXX, 8'h90);

        // Asynchronous reset mid-FETCH with a valid head.
        start = 1'b1;
        instr_ready = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("pre_reset_valid", instr_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_valid", instr_valid, 1'b0);
        check("async_rom_read", rom_read, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_halted", halted, 1'b0);
        check("async_rom_addr", rom_addr, RESET_PC);
        m_run = 0;
        m_halted = 0;
        exp_pc = RESET_PC;
        outstanding = 0;
        @(posedge clock);
        #1 reset = 1'b0;

        // Random traffic over a fresh program with sparse HALTs.
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 23) == 0) ? {4'hF, 12'($urandom)}
                                                  : {4'($urandom_range(0, 14)), 12'($urandom)};
        for (int n = 0; n < 4000; n++) begin
            start       = ($urandom_range(0, 3) == 0);
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 8'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
